// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths, opcode encodings and the
// load-button index map used by the input loader.
package alu_pkg;

  localparam int NB_DATA = 4;
  localparam int NB_OP   = 6;

  typedef enum logic [5:0] {
    OP_ADD = 6'b100000,
    OP_SUB = 6'b100010,
    OP_AND = 6'b100100,
    OP_OR  = 6'b100101,
    OP_XOR = 6'b100110,
    OP_SRA = 6'b000011,
    OP_SRL = 6'b000010,
    OP_NOR = 6'b100111
  } op_e;

  localparam logic [5:0] OP_RESET = OP_ADD;

  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

endpackage

// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and ALU operand outputs of the input loader, bundled
// with a slave view (the loader) and a master view (whoever drives the board).
interface alu_input_loader_if #(
  parameter int NB_SW   = 8,
  parameter int NB_BTN  = 3,
  parameter int NB_DATA = 4,
  parameter int NB_OP   = 6
);
  logic [NB_SW-1:0]   i_sw;
  logic [NB_BTN-1:0]  i_btn;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic [NB_OP-1:0]   o_operation;
  logic               o_load;
  logic               o_ready;

  modport slave (
    input  i_sw, i_btn,
    output o_datoA, o_datoB, o_operation, o_load, o_ready
  );

  modport master (
    output i_sw, i_btn,
    input  o_datoA, o_datoB, o_operation, o_load, o_ready
  );
endinterface

// File: rtl/alu_input_loader_btn_debounce.sv
// One push-button: 2-FF synchroniser, optional debouncer and rising-edge pulse.
// Debouncer present only when ALU_IN_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NB_CNT          = 20
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic btn_raw,
  output logic pulse
);

  logic [1:0] sync_r;

  // two-stage synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
    end
  end

`ifdef ALU_IN_DEBOUNCE_EN
  logic [NB_CNT-1:0] cnt_r;
  logic              stable_r;
  logic              differ_s;
  logic              toggle_s;

  assign differ_s = sync_r[1] ^ stable_r;
  assign toggle_s = differ_s && (cnt_r == NB_CNT'(DEBOUNCE_CYCLES - 1));

  // count consecutive samples disagreeing with the accepted level
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else if (!differ_s) begin
      cnt_r    <= '0;
    end else if (toggle_s) begin
      cnt_r    <= '0;
      stable_r <= ~stable_r;
    end else begin
      cnt_r    <= cnt_r + NB_CNT'(1);
    end
  end

  // the pulse coincides with the 0->1 acceptance so the load lands on the same edge
  assign pulse = toggle_s & ~stable_r;
`else
  logic stable_d_r;
  logic unused_cfg_s;

  assign unused_cfg_s = (DEBOUNCE_CYCLES == NB_CNT);

  // delayed copy of the synchronised level for edge detection
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_d_r <= 1'b0;
    end else begin
      stable_d_r <= sync_r[1];
    end
  end

  assign pulse = sync_r[1] & ~stable_d_r;
`endif

endmodule

// File: rtl/alu_input_loader.sv
// ALU operand/opcode loader: switches are captured into A, B or Op registers
// on a debounced button press. Optional debouncer: ALU_IN_DEBOUNCE_EN.
module alu_input_loader #(
  parameter int NB_DATA         = alu_pkg::NB_DATA,
  parameter int NB_OP           = alu_pkg::NB_OP,
  parameter int NB_SW           = 8,
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NB_CNT          = 20
) (
  input  logic                clk,
  input  logic                i_rst_n,
  alu_input_loader_if.slave   bus
);
  import alu_pkg::*;

  logic [NB_SW-1:0]   sw_meta_r;
  logic [NB_SW-1:0]   sw_sync_r;
  logic [NB_BTN-1:0]  pulse_s;
  logic [NB_BTN-1:0]  flags_r;
  logic [NB_BTN-1:0]  flags_next_s;
  logic [NB_DATA-1:0] dato_a_r;
  logic [NB_DATA-1:0] dato_b_r;
  logic [NB_OP-1:0]   op_r;
  logic               load_r;
  logic               ready_r;
  logic               unused_sw_s;

  assign unused_sw_s = ^sw_sync_r;

  for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NB_CNT          (NB_CNT)
    ) u_btn (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .btn_raw (bus.i_btn[g]),
      .pulse   (pulse_s[g])
    );
  end

  // loaded flags including any load happening this cycle, so o_ready rises with the third load
  always_comb begin
    flags_next_s = flags_r | pulse_s;
  end

  // two-stage synchroniser for the switch bus
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_r <= '0;
      sw_sync_r <= '0;
    end else begin
      sw_meta_r <= bus.i_sw;
      sw_sync_r <= sw_meta_r;
    end
  end

  // operand/opcode registers, load strobe and ready status
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dato_a_r <= '0;
      dato_b_r <= '0;
      op_r     <= NB_OP'(OP_RESET);
      load_r   <= 1'b0;
      flags_r  <= '0;
      ready_r  <= 1'b0;
    end else begin
      if (pulse_s[BTN_A]) begin
        dato_a_r <= sw_sync_r[NB_DATA-1:0];
      end
      if (pulse_s[BTN_B]) begin
        dato_b_r <= sw_sync_r[NB_DATA-1:0];
      end
      if (pulse_s[BTN_OP]) begin
        op_r <= sw_sync_r[NB_OP-1:0];
      end
      load_r  <= |pulse_s;
      flags_r <= flags_next_s;
      ready_r <= ready_r | (&flags_next_s);
    end
  end

  assign bus.o_datoA     = dato_a_r;
  assign bus.o_datoB     = dato_b_r;
  assign bus.o_operation = op_r;
  assign bus.o_load      = load_r;
  assign bus.o_ready     = ready_r;

endmodule

// File: tb/tb_alu_input_loader.sv
// Scoreboard bench for alu_input_loader: a sample-window reference model
// predicts each load; a negedge monitor checks every output cycle.
module tb_alu_input_loader;
  import alu_pkg::*;

  localparam int DEB = 4;
`ifdef ALU_IN_DEBOUNCE_EN
  localparam int D_EFF = DEB;
`else
  localparam int D_EFF = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_input_loader_if #(.NB_SW(8), .NB_BTN(3), .NB_DATA(4), .NB_OP(6)) bus ();

  alu_input_loader #(
    .NB_DATA(4), .NB_OP(6), .NB_SW(8), .NB_BTN(3),
    .DEBOUNCE_CYCLES(DEB), .NB_CNT(3)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] op;
    logic       ready;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a level is accepted once the last D_EFF synchronised
  // samples all disagree with it; a load happens when a button is accepted high.
  logic [2:0] bh [0:D_EFF];
  logic [7:0] swh [0:1];
  logic [2:0] m_stable;
  logic [2:0] m_flags;
  logic [3:0] m_a, m_b;
  logic [5:0] m_op;
  logic       m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= D_EFF; k++) bh[k] <= 3'b000;
      swh[0] <= 8'h00; swh[1] <= 8'h00;
      m_stable <= 3'b000; m_flags <= 3'b000;
      m_a <= 4'h0; m_b <= 4'h0; m_op <= OP_RESET; m_ready <= 1'b0;
      q.delete();
    end else begin
      logic [2:0] st, pulse, fl;
      logic [3:0] na, nb;
      logic [5:0] nop;
      logic       all_diff, rdy;
      st = m_stable; pulse = 3'b000;
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D_EFF; k++)
          if (bh[k][b] == st[b]) all_diff = 1'b0;
        if (all_diff) begin
          st[b] = ~st[b];
          if (st[b]) pulse[b] = 1'b1;
        end
      end
      na  = pulse[0] ? swh[1][3:0] : m_a;
      nb  = pulse[1] ? swh[1][3:0] : m_b;
      nop = pulse[2] ? swh[1][5:0] : m_op;
      fl  = m_flags | pulse;
      rdy = m_ready | (fl == 3'b111);
      if (pulse != 3'b000) q.push_back('{a: na, b: nb, op: nop, ready: rdy});
      m_stable <= st; m_flags <= fl; m_ready <= rdy;
      m_a <= na; m_b <= nb; m_op <= nop;
      for (int k = 1; k <= D_EFF; k++) bh[k] <= bh[k-1];
      bh[0]  <= bus.i_btn;
      swh[1] <= swh[0];
      swh[0] <= bus.i_sw;
    end
  end

  // Monitor: pop on every o_load, otherwise outputs must hold their last value.
  exp_t held = '{a: 4'h0, b: 4'h0, op: OP_RESET, ready: 1'b0};

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_datoA", 32'(bus.o_datoA), 32'h0);
      chk("rst_datoB", 32'(bus.o_datoB), 32'h0);
      chk("rst_operation", 32'(bus.o_operation), 32'h20);
      chk("rst_load", 32'(bus.o_load), 32'h0);
      chk("rst_ready", 32'(bus.o_ready), 32'h0);
      held <= '{a: 4'h0, b: 4'h0, op: OP_RESET, ready: 1'b0};
    end else if (bus.o_load) begin
      if (q.size() == 0) begin
        chk("spurious_load", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("load_datoA", 32'(bus.o_datoA), 32'(e.a));
        chk("load_datoB", 32'(bus.o_datoB), 32'(e.b));
        chk("load_operation", 32'(bus.o_operation), 32'(e.op));
        chk("load_ready", 32'(bus.o_ready), 32'(e.ready));
        held <= e;
      end
    end else begin
      chk("missing_load", 32'(q.size()), 32'd0);
      chk("hold_datoA", 32'(bus.o_datoA), 32'(held.a));
      chk("hold_datoB", 32'(bus.o_datoB), 32'(held.b));
      chk("hold_operation", 32'(bus.o_operation), 32'(held.op));
      chk("hold_ready", 32'(bus.o_ready), 32'(held.ready));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx, input logic [7:0] v);
    logic [2:0] one;
    one = 3'b001;
    bus.i_sw  = v;
    bus.i_btn = one << idx;
    cyc(DEB + 4);
    bus.i_btn = 3'b000;
    cyc(DEB + 4);
  endtask

  initial begin
    logic [3:0] diff;
    bus.i_sw  = 8'($urandom);
    bus.i_btn = 3'b000;
    rst_n     = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    bus.i_sw = 8'($urandom);
    cyc(6);

    // latency: single A press
    bus.i_sw = 8'h0A; bus.i_btn = 3'b001;
    cyc(10);
    bus.i_btn = 3'b000;
    cyc(12);

    // short B glitch, then long hold while the switches move
    bus.i_sw = 8'h05; bus.i_btn = 3'b010;
    cyc(3);
    bus.i_btn = 3'b000;
    cyc(10);
    bus.i_btn = 3'b010;
    for (int i = 0; i < 50; i++) begin
      bus.i_sw = 8'($urandom);
      cyc(1);
    end
    bus.i_btn = 3'b000;
    cyc(12);

    // full sequence from a fresh reset: A=3, B=1, Op=SUB
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    press(BTN_A, 8'h03);
    press(BTN_B, 8'h01);
    press(BTN_OP, 8'h22);
    diff = bus.o_datoA - bus.o_datoB;
    chk("alu_sub_result", 32'(diff), 32'h2);

    // simultaneous A and B
    bus.i_sw = 8'hC7; bus.i_btn = 3'b011;
    cyc(10);
    bus.i_btn = 3'b000;
    cyc(10);

    // reset in the middle of an Op press, button kept held through release
    bus.i_sw = 8'($urandom); bus.i_btn = 3'b100;
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(DEB + 6);
    bus.i_btn = 3'b000;
    cyc(10);

    // random presses of random length on random buttons
    for (int i = 0; i < 40; i++) begin
      bus.i_sw  = 8'($urandom);
      bus.i_btn = 3'($urandom_range(0, 7));
      cyc($urandom_range(1, 8));
      bus.i_sw  = 8'($urandom);
      bus.i_btn = 3'b000;
      cyc($urandom_range(1, 8));
    end
    cyc(DEB + 8);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_input_loader.md
Name: alu_input_loader

Overview:
- Upstream stage of the ALU: captures operands and opcode from board switches under push-button control.
- Holds them in registers that drive the ALU's i_datoA, i_datoB and i_operation directly.
- Each button is synchronised, debounced and edge-detected, so one press performs exactly one load.
- Gives the ALU a defined, reset-controlled operand and opcode set instead of floating switch inputs.

Parameters:
NB_DATA, 4, width of operands A and B
NB_OP, 6, width of the opcode
NB_SW, 8, switch bus width; must be >= NB_DATA and >= NB_OP
NB_BTN, 3, number of load buttons (fixed order: A, B, Op)
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change; >= 2
NB_CNT, 20, debounce counter width; 2**NB_CNT > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_sw  input  NB_SW  raw switches, asynchronous
i_btn  input  NB_BTN  raw buttons, active high, asynchronous; [0]=load A, [1]=load B, [2]=load Op
o_datoA  output  NB_DATA  operand A register, to ALU i_datoA
o_datoB  output  NB_DATA  operand B register, to ALU i_datoB
o_operation  output  NB_OP  opcode register, to ALU i_operation
o_load  output  1  one-cycle pulse, the cycle after any register update
o_ready  output  1  high once A, B and Op have each been loaded since reset

Behaviour:
- Reset: one clock (clk); reset (i_rst_n) is asynchronous and active-low.
  - Reset values: o_datoA=0, o_datoB=0, o_operation=6'b100000 (ADD), o_load=0, o_ready=0.
  - Internal: loaded flags=0, synchronisers=0, stable levels=0, counters=0.
- Switches: i_sw passes through a 2-FF synchroniser.
  - A and B load from sw_sync[NB_DATA-1:0]; Op loads from sw_sync[NB_OP-1:0].
- Per button, three steps:
  - 2-FF synchroniser.
  - Debouncer: counter increments on each edge where sync differs from the stable level. It clears whenever sync equals the stable level. On the edge where the counter is at DEBOUNCE_CYCLES-1 and still differs, the stable level toggles and the counter clears.
  - Rising-edge detector: pulse = stable & ~stable_d.
- Load: at the edge where a button's pulse is high, the matching register captures the switches.
- Latency: hold a button from the edge that first samples it high (edge 1). The register updates on edge DEBOUNCE_CYCLES+2. o_load is high for the following cycle.
- Glitch rejection: a press or release shorter than DEBOUNCE_CYCLES samples causes no level change and no load.
- Held button: exactly one load per press. A new load requires release (debounced) and re-press.
- Simultaneous pulses: each affected register loads in the same cycle from the same switch value. o_load pulses once.
- o_ready: set on the cycle all three loaded flags are 1; cleared only by reset.
- Switch changes alone never alter the outputs.
- Reset mid-debounce or mid-press: all state clears immediately and no load occurs.
  - A button still held after reset release is treated as a new press (stable level is 0 after reset).
- Opcode values are not validated; any NB_OP pattern is stored.

Optional Feature:
- Macro: ALU_IN_DEBOUNCE_EN.
- Defined: debouncer present as above.
- Undefined: the debouncer is removed and the stable level equals the synchroniser output. Load latency becomes 3 edges (edge 3). Glitch rejection is lost; the one-load-per-press edge detection is kept. This build is intended for fast simulation.
- DEBOUNCE_CYCLES and NB_CNT are ignored when undefined.

Decomposition:
- Package alu_pkg:
  - NB_DATA and NB_OP defaults.
  - Opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR.
  - OP_RESET = OP_ADD.
  - Button index constants BTN_A=0, BTN_B=1, BTN_OP=2.
  - Shared with the ALU.
- Sub-module btn_debounce: synchroniser, counter, stable level and edge pulse for one button.
  - Instantiated NB_BTN times via generate.
  - The ALU_IN_DEBOUNCE_EN conditional lives inside btn_debounce.

Test Plan:
- Reset check: DEBOUNCE_CYCLES=4; assert reset with random switches -> datoA=0, datoB=0, operation=6'b100000, o_ready=0. After release, no output change until a button is pressed.
- Load latency: sw=8'h0A, hold btn[0] 10 cycles -> o_datoA=4'hA exactly on edge 6. o_load is high for one cycle and datoB/operation are unchanged.
- Glitch and hold: a btn[1] pulse of 3 cycles with sw=8'h05 -> no load. Hold btn[1] for 50 cycles while changing sw after the load -> exactly one load with the value present at the load edge.
- Full sequence: load A=4'h3, B=4'h1, Op=6'b100010 -> o_ready rises on the cycle of the third load. The downstream ALU output reads 4'h2.
- Simultaneous press: btn[0] and btn[1] together with sw=8'hC7 -> datoA=4'h7 and datoB=4'h7 on the same edge, with a single o_load pulse.
- Mid-operation reset: assert i_rst_n low at counter=2 during a btn[2] press -> outputs at reset values. With the button still held after release -> Op loads DEBOUNCE_CYCLES+2 edges after release. Repeat the latency test with ALU_IN_DEBOUNCE_EN undefined -> update on edge 3.
